shared_adder_arb: RTL
=====================

# shared_adder_arb

Round-robin arbiter and sequencer that shares the single WIDTH-bit adder datapath of the chip top between two requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one pair per cycle into the adder and registers the sum and carry into a one-entry response slot tagged with the requester id. It sits between the pin-level input decode and the output mux of the top-level module.

## Interface
- WIDTH, 8, operand and sum width in bits
- CNT_W, 16, width of the completed-operation counter
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- ena  input  1  global enable; when low, no new grants are issued
- req0_valid  input  1  requester 0 has an operand pair
- req0_a, req0_b  input  WIDTH  requester 0 operands
- req0_ready  output  1  requester 0 pair accepted this cycle
- req1_valid  input  1  requester 1 has an operand pair
- req1_a, req1_b  input  WIDTH  requester 1 operands
- req1_ready  output  1  requester 1 pair accepted this cycle
- rsp_valid  output  1  response slot full
- rsp_ready  input  1  consumer takes the response this cycle
- rsp_id  output  1  id of the requester that produced the response
- rsp_sum  output  WIDTH  (a + b) mod 2^WIDTH
- rsp_carry  output  1  bit WIDTH of a + b
- busy  output  1  equals rsp_valid
- op_count  output  CNT_W  number of responses consumed; wraps modulo 2^CNT_W

## Operation
- Slot state machine with two states. EMPTY means rsp_valid=0; FULL means rsp_valid=1.
- Define slot_free = EMPTY or (FULL and rsp_ready).
- Grant logic is combinational:
  - If only one requester is valid, that requester is the candidate.
  - If both are valid, the candidate is the requester other than last_grant.
  - req_ready of the candidate is ena and slot_free; the other req_ready is 0.
  - At most one req_ready is high in any cycle.
- Accept means req_valid and req_ready are both high for the same requester. On accept:
  - rsp_sum and rsp_carry load {carry, sum} = a + b, computed at WIDTH+1 bits.
  - rsp_id loads the granted index.
  - last_grant loads the granted index.
  - The slot goes to FULL (or stays FULL).
- Drain means rsp_valid and rsp_ready are both high. On drain:
  - op_count increments.
  - If there is no simultaneous accept, the slot goes to EMPTY.
- Simultaneous drain and accept: the slot stays FULL with the new payload. This gives one result per cycle at full throughput.
- While FULL and not draining, rsp_id, rsp_sum and rsp_carry hold stable.
- Requesters must hold valid and operands until ready. Dropping valid before ready is tolerated: nothing is captured and last_grant does not change.
- ena low blocks accepts only. A held response still drains, and op_count still counts.
- last_grant updates only on accept, never on an idle or blocked cycle.

## Timing
- Reset (async assert, sync deassert by the environment) sets the following:
  - rsp_valid=0, busy=0, rsp_id=0, rsp_sum=0, rsp_carry=0
  - op_count=0, last_grant=1, so requester 0 wins the first contention.
  - req0_ready and req1_ready are 0 during reset.
- Reset mid-operation discards any held response. No drain is counted.
- Latency: an accept in cycle N gives rsp_valid=1 with its payload in cycle N+1.
- req_ready may depend combinationally on req_valid, ena, rsp_valid and rsp_ready. There is no combinational path from operands to any output.
- Sustained throughput is one operation per cycle when rsp_ready is held high.
- With both requesters held valid and rsp_ready=1, grants alternate 0,1,0,1,...
- op_count wraps from 2^CNT_W-1 to 0 with no flag.

## Test plan
- Reset, then req0 a=0x12 b=0x34 valid for one cycle:
  - req0_ready=1 in the same cycle.
  - Next cycle: rsp_valid=1, rsp_id=0, rsp_sum=0x46, rsp_carry=0.
  - rsp_ready=1 gives op_count=1.
- Carry boundary: req1 a=0xFF b=0x01 gives rsp_sum=0x00, rsp_carry=1, rsp_id=1. Also a=0xFF b=0xFF gives 0xFE, carry=1.
- Contention: both valid continuously with rsp_ready=1 for 6 cycles. Grants and rsp_id go 0,1,0,1,0,1, giving 6 responses in 6 cycles plus 1 cycle latency.
- Backpressure: rsp_ready=0 with a response held. Both req_ready stay 0 and the payload stays stable for 5 cycles. Raising rsp_ready gives a drain and an accept in the same cycle, and the new payload appears the next cycle.
- ena=0 with req0 valid: req0_ready stays 0 and no response appears. A previously held response still drains. ena=1 resumes the grant.
- Assert rst_n low while FULL: rsp_valid=0 immediately and op_count=0. After release, the first contention grants requester 0. Preload op_count to 0xFFFF via drains; one more drain gives 0x0000.

Source files
------------

// File: rtl/shared_adder_arb.sv
// Round-robin arbiter that shares one WIDTH-bit adder between two requesters
// and holds each result in a one-entry response slot tagged with its source id.
module shared_adder_arb #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_carry,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  slot_state_t      state_reg, state_next;
  logic             last_grant_reg, last_grant_next;
  logic             id_reg, id_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             carry_reg, carry_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic [1:0]       req_valid;
  logic [1:0]       req_ready_vec;
  logic [WIDTH-1:0] op_a [2];
  logic [WIDTH-1:0] op_b [2];
  logic             cand;
  logic             slot_free;
  logic             grant_ok;
  logic             accept;
  logic             drain;
  logic [WIDTH:0]   sum_full;

  assign req_valid = {req1_valid, req0_valid};
  assign op_a[0]   = req0_a;
  assign op_b[0]   = req0_b;
  assign op_a[1]   = req1_a;
  assign op_b[1]   = req1_b;

  // Lone requester wins outright; under contention the one not granted last wins.
  assign cand      = req_valid[1] & (~req_valid[0] | ~last_grant_reg);
  assign drain     = (state_reg == FULL) & rsp_ready;
  assign slot_free = (state_reg == EMPTY) | rsp_ready;
  // rst_n gating keeps both readies low while reset is held.
  assign grant_ok  = rst_n & ena & slot_free;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign req_ready_vec[gi] = grant_ok & req_valid[gi] & (cand == 1'(gi));
    end
  endgenerate

  assign req0_ready = req_ready_vec[0];
  assign req1_ready = req_ready_vec[1];
  assign accept     = |req_ready_vec;
  assign sum_full   = {1'b0, op_a[cand]} + {1'b0, op_b[cand]};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY:   if (accept) state_next = FULL;
      FULL:    if (drain && !accept) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    last_grant_next = last_grant_reg;
    id_next         = id_reg;
    sum_next        = sum_reg;
    carry_next      = carry_reg;
    count_next      = count_reg;
    if (accept) begin
      last_grant_next = cand;
      id_next         = cand;
      sum_next        = sum_full[WIDTH-1:0];
      carry_next      = sum_full[WIDTH];
    end
    if (drain) begin
      count_next = count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= EMPTY;
      last_grant_reg <= 1'b1;
      id_reg         <= 1'b0;
      sum_reg        <= '0;
      carry_reg      <= 1'b0;
      count_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      id_reg         <= id_next;
      sum_reg        <= sum_next;
      carry_reg      <= carry_next;
      count_reg      <= count_next;
    end
  end

  assign rsp_valid = (state_reg == FULL);
  assign busy      = rsp_valid;
  assign rsp_id    = id_reg;
  assign rsp_sum   = sum_reg;
  assign rsp_carry = carry_reg;
  assign op_count  = count_reg;

endmodule
